// File: rtl/mul_rs_scheduler.sv
// mul_rs_scheduler
// Reservation station and dispatch controller for the multiplier unit of
// the Tomasulo core. It buffers MUL instructions from issue, snoops the CDB
// for outstanding source tags, and hands the oldest fully-ready entry to the
// multiplier whenever the multiplier is free.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   issue_valid/issue_ready        issue handshake (ready = a slot is free)
//   issue_tag                      destination tag of the incoming MUL
//   issue_rdy3/val3/src3           operand3: ready flag, value, producer tag
//   issue_rdy4/val4/src4           operand4: ready flag, value, producer tag
//   cdb_valid/cdb_tag/cdb_data     common data bus broadcast
//   mul_done                       multiplier result broadcast pulse
//   mul_start                      one-cycle dispatch strobe
//   mul_tag/mul_op3/mul_op4        dispatched instruction, held until the next dispatch
//   mul_busy                       multiplier occupied (waiting for mul_done)
//   occupancy                      number of valid entries
module mul_rs_scheduler #(
  parameter int ENTRIES = 4,
  parameter int DATA_W  = 8,
  parameter int TAG_W   = 3,
  parameter int AGE_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic [TAG_W-1:0]          issue_tag,
  input  logic                      issue_rdy3,
  input  logic [DATA_W-1:0]         issue_val3,
  input  logic [TAG_W-1:0]          issue_src3,
  input  logic                      issue_rdy4,
  input  logic [DATA_W-1:0]         issue_val4,
  input  logic [TAG_W-1:0]          issue_src4,
  output logic                      issue_ready,
  input  logic                      cdb_valid,
  input  logic [TAG_W-1:0]          cdb_tag,
  input  logic [DATA_W-1:0]         cdb_data,
  input  logic                      mul_done,
  output logic                      mul_start,
  output logic [TAG_W-1:0]          mul_tag,
  output logic [DATA_W-1:0]         mul_op3,
  output logic [DATA_W-1:0]         mul_op4,
  output logic                      mul_busy,
  output logic [$clog2(ENTRIES):0]  occupancy
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t state;

  logic [ENTRIES-1:0] ent_vld;
  logic [ENTRIES-1:0] ent_rdy3;
  logic [ENTRIES-1:0] ent_rdy4;
  logic [TAG_W-1:0]   ent_dtag [ENTRIES];
  logic [DATA_W-1:0]  ent_val3 [ENTRIES];
  logic [DATA_W-1:0]  ent_val4 [ENTRIES];
  logic [TAG_W-1:0]   ent_src3 [ENTRIES];
  logic [TAG_W-1:0]   ent_src4 [ENTRIES];
  logic [AGE_W-1:0]   ent_age  [ENTRIES];

  logic [ENTRIES-1:0] ent_ready;
  logic [CNT_W-1:0]   occ_cnt;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [AGE_W-1:0]   sel_age;
  logic               alloc;
  logic               dispatch;
  logic               byp3;
  logic               byp4;

  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
    return (a == AGE_MAX) ? a : a + AGE_W'(1);
  endfunction

  // Readiness comes from registered bits only, so a wakeup or allocation
  // becomes eligible for dispatch one edge later.
  assign ent_ready = ent_vld & ent_rdy3 & ent_rdy4;

  always_comb begin
    occ_cnt    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_age    = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      occ_cnt = occ_cnt + CNT_W'(ent_vld[i]);
      if (!ent_vld[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      // Strict '>' keeps the lowest index on equal ages.
      if (ent_ready[i] && (!sel_found || ent_age[i] > sel_age)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = ent_age[i];
      end
    end
  end

  assign occupancy   = occ_cnt;
  assign issue_ready = (occ_cnt < CNT_W'(ENTRIES));
  // The free slot is chosen from registered valid bits, so a slot being
  // vacated by this cycle's dispatch is never reused in the same cycle.
  assign alloc       = issue_valid & free_found;
  assign dispatch    = (state == S_IDLE) & sel_found;

  // Operands arriving on the same cycle their producer broadcasts.
  assign byp3 = cdb_valid & ~issue_rdy3 & (issue_src3 == cdb_tag);
  assign byp4 = cdb_valid & ~issue_rdy4 & (issue_src4 == cdb_tag);

  // Control: entry valid bits, dispatch FSM and the dispatch output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ent_vld   <= '0;
      mul_start <= 1'b0;
      mul_busy  <= 1'b0;
      mul_tag   <= '0;
      mul_op3   <= '0;
      mul_op4   <= '0;
    end else begin
      mul_start <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        if (dispatch && sel_idx == IDX_W'(i)) begin
          ent_vld[i] <= 1'b0;
        end else if (alloc && free_idx == IDX_W'(i)) begin
          ent_vld[i] <= 1'b1;
        end
      end
      case (state)
        S_IDLE: begin
          if (sel_found) begin
            mul_start <= 1'b1;
            mul_tag   <= ent_dtag[sel_idx];
            mul_op3   <= ent_val3[sel_idx];
            mul_op4   <= ent_val4[sel_idx];
            mul_busy  <= 1'b1;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mul_done) begin
            mul_busy <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Entry payload: written on allocation, updated by CDB capture and aging.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (alloc && free_idx == IDX_W'(i)) begin
        ent_dtag[i] <= issue_tag;
        ent_rdy3[i] <= issue_rdy3 | byp3;
        ent_val3[i] <= issue_rdy3 ? issue_val3 : cdb_data;
        ent_src3[i] <= issue_src3;
        ent_rdy4[i] <= issue_rdy4 | byp4;
        ent_val4[i] <= issue_rdy4 ? issue_val4 : cdb_data;
        ent_src4[i] <= issue_src4;
        ent_age[i]  <= '0;
      end else if (ent_vld[i]) begin
        if (cdb_valid && !ent_rdy3[i] && ent_src3[i] == cdb_tag) begin
          ent_rdy3[i] <= 1'b1;
          ent_val3[i] <= cdb_data;
        end
        if (cdb_valid && !ent_rdy4[i] && ent_src4[i] == cdb_tag) begin
          ent_rdy4[i] <= 1'b1;
          ent_val4[i] <= cdb_data;
        end
        ent_age[i] <= age_inc(ent_age[i]);
      end
    end
  end

endmodule

// File: tb/tb_mul_rs_scheduler.sv
// Testbench for mul_rs_scheduler: directed issue/CDB/done sequences with a
// dispatch scoreboard. Expected dispatches are queued in hand-computed order
// as stimulus is issued; a monitor pops and compares on every mul_start.
module tb_mul_rs_scheduler;

  localparam int ENTRIES = 4;
  localparam int DATA_W  = 8;
  localparam int TAG_W   = 3;
  localparam int AGE_W   = 3;

  logic              clk;
  logic              rst;
  logic              issue_valid;
  logic [TAG_W-1:0]  issue_tag;
  logic              issue_rdy3;
  logic [DATA_W-1:0] issue_val3;
  logic [TAG_W-1:0]  issue_src3;
  logic              issue_rdy4;
  logic [DATA_W-1:0] issue_val4;
  logic [TAG_W-1:0]  issue_src4;
  logic              issue_ready;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              mul_done;
  logic              mul_start;
  logic [TAG_W-1:0]  mul_tag;
  logic [DATA_W-1:0] mul_op3;
  logic [DATA_W-1:0] mul_op4;
  logic              mul_busy;
  logic [$clog2(ENTRIES):0] occupancy;

  mul_rs_scheduler #(
    .ENTRIES(ENTRIES), .DATA_W(DATA_W), .TAG_W(TAG_W), .AGE_W(AGE_W)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_tag(issue_tag),
    .issue_rdy3(issue_rdy3), .issue_val3(issue_val3), .issue_src3(issue_src3),
    .issue_rdy4(issue_rdy4), .issue_val4(issue_val4), .issue_src4(issue_src4),
    .issue_ready(issue_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .mul_done(mul_done), .mul_start(mul_start),
    .mul_tag(mul_tag), .mul_op3(mul_op3), .mul_op4(mul_op4),
    .mul_busy(mul_busy), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] op3;
    logic [DATA_W-1:0] op4;
  } disp_t;

  disp_t exp_q[$];
  disp_t mon_e;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] a,
                      input logic [DATA_W-1:0] b);
    disp_t d;
    d.tag = t;
    d.op3 = a;
    d.op4 = b;
    exp_q.push_back(d);
  endtask

  // Scoreboard monitor: every dispatch strobe must match the queue head.
  always @(negedge clk) begin
    if (mul_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_dispatch: got tag=%0d op3=%0d op4=%0d, expected no dispatch",
                 mul_tag, mul_op3, mul_op4);
      end else begin
        mon_e = exp_q.pop_front();
        check("dispatch", 32'({mul_tag, mul_op3, mul_op4}), 32'(mon_e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue_cycle(input logic [TAG_W-1:0] t,
                             input logic r3, input logic [DATA_W-1:0] v3, input logic [TAG_W-1:0] s3,
                             input logic r4, input logic [DATA_W-1:0] v4, input logic [TAG_W-1:0] s4);
    issue_valid = 1'b1;
    issue_tag   = t;
    issue_rdy3  = r3;
    issue_val3  = v3;
    issue_src3  = s3;
    issue_rdy4  = r4;
    issue_val4  = v4;
    issue_src4  = s4;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic do_done();
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    issue_valid = 1'b0; issue_tag = '0;
    issue_rdy3 = 1'b0; issue_val3 = '0; issue_src3 = '0;
    issue_rdy4 = 1'b0; issue_val4 = '0; issue_src4 = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    mul_done = 1'b0;
    @(negedge clk);
    tick();
    tick();

    // Reset state
    check("rst_start", 32'(mul_start), 32'd0);
    check("rst_tag", 32'(mul_tag), 32'd0);
    check("rst_op3", 32'(mul_op3), 32'd0);
    check("rst_op4", 32'(mul_op4), 32'd0);
    check("rst_busy", 32'(mul_busy), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_issue_ready", 32'(issue_ready), 32'd1);
    rst = 1'b0;

    // 1: both operands ready, dispatch one edge after allocation
    push(3, 5, 6);
    issue_cycle(3, 1, 5, 0, 1, 6, 0);
    check("t1_occ_alloc", 32'(occupancy), 32'd1);
    check("t1_no_early_start", 32'(mul_start), 32'd0);
    tick();
    check("t1_start", 32'(mul_start), 32'd1);
    check("t1_busy", 32'(mul_busy), 32'd1);
    check("t1_occ_after", 32'(occupancy), 32'd0);
    tick();
    check("t1_start_pulse", 32'(mul_start), 32'd0);
    check("t1_busy_hold", 32'(mul_busy), 32'd1);
    do_done();
    check("t1_busy_clear", 32'(mul_busy), 32'd0);
    check("t1_tag_held", 32'(mul_tag), 32'd3);

    // 2: operand3 woken by CDB two cycles after issue
    push(1, 9, 2);
    issue_cycle(1, 0, 0, 4, 1, 2, 0);
    tick();
    check("t2_waiting", 32'(mul_start), 32'd0);
    cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 8'd9;
    tick();
    cdb_valid = 1'b0;
    check("t2_no_start_on_wake", 32'(mul_start), 32'd0);
    tick();
    check("t2_start", 32'(mul_start), 32'd1);
    do_done();

    // 3: issue bypass, both operands on the same CDB tag
    push(5, 7, 7);
    cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 8'd7;
    issue_cycle(5, 0, 0, 6, 0, 0, 6);
    cdb_valid = 1'b0;
    tick();
    check("t3_start", 32'(mul_start), 32'd1);
    do_done();

    // 4: fill while the multiplier is busy, drop a fifth issue
    push(2, 1, 1);
    issue_cycle(2, 1, 1, 0, 1, 1, 0);
    tick();
    check("t4_busy", 32'(mul_busy), 32'd1);
    push(4, 10, 11);
    push(5, 12, 13);
    push(6, 14, 15);
    push(7, 20, 21);
    issue_cycle(4, 1, 10, 0, 1, 11, 0);
    issue_cycle(5, 1, 12, 0, 1, 13, 0);
    issue_cycle(6, 1, 14, 0, 1, 15, 0);
    issue_cycle(7, 1, 20, 0, 1, 21, 0);
    check("t4_occ_full", 32'(occupancy), 32'd4);
    check("t4_not_ready", 32'(issue_ready), 32'd0);
    issue_cycle(0, 1, 99, 0, 1, 99, 0);
    check("t4_drop_occ", 32'(occupancy), 32'd4);
    do_done();
    check("t4_no_start_on_done", 32'(mul_start), 32'd0);
    tick();
    check("t4_start_oldest", 32'(mul_start), 32'd1);
    check("t4_occ_3", 32'(occupancy), 32'd3);
    check("t4_ready_again", 32'(issue_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      do_done();
      tick();
    end
    do_done();
    check("t4_drained", 32'(occupancy), 32'd0);
    check("t4_idle", 32'(mul_busy), 32'd0);

    // 5: age beats index (slot 2 older than slot 0)
    push(1, 1, 2);
    push(6, 60, 61);
    push(3, 30, 31);
    push(5, 50, 51);
    push(2, 70, 40);
    issue_cycle(1, 1, 1, 0, 1, 2, 0);
    issue_cycle(2, 0, 0, 7, 1, 40, 0);
    check("t5_first_start", 32'(mul_start), 32'd1);
    issue_cycle(6, 1, 60, 0, 1, 61, 0);
    issue_cycle(3, 1, 30, 0, 1, 31, 0);
    check("t5_occ_3", 32'(occupancy), 32'd3);
    do_done();
    tick();
    check("t5_tag_slot0_old", 32'(mul_tag), 32'd6);
    issue_cycle(5, 1, 50, 0, 1, 51, 0);
    do_done();
    tick();
    check("t5_slot2_first", 32'(mul_tag), 32'd3);
    do_done();
    tick();
    check("t5_slot0_next", 32'(mul_tag), 32'd5);
    mul_done = 1'b1;
    cdb_valid = 1'b1; cdb_tag = 3'd7; cdb_data = 8'd70;
    tick();
    mul_done = 1'b0;
    cdb_valid = 1'b0;
    tick();
    check("t5_woken_start", 32'(mul_start), 32'd1);
    do_done();
    check("t5_occ_0", 32'(occupancy), 32'd0);

    // 6: reset while waiting with two valid entries
    push(1, 1, 1);
    issue_cycle(1, 1, 1, 0, 1, 1, 0);
    issue_cycle(2, 0, 0, 0, 1, 3, 0);
    issue_cycle(3, 1, 4, 0, 1, 5, 0);
    check("t6_occ_2", 32'(occupancy), 32'd2);
    check("t6_busy", 32'(mul_busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_occ_rst", 32'(occupancy), 32'd0);
    check("t6_busy_rst", 32'(mul_busy), 32'd0);
    check("t6_start_rst", 32'(mul_start), 32'd0);
    check("t6_tag_rst", 32'(mul_tag), 32'd0);
    check("t6_ready_rst", 32'(issue_ready), 32'd1);
    do_done();
    check("t6_done_ignored", 32'(mul_busy), 32'd0);
    tick();
    tick();
    check("t6_no_start", 32'(mul_start), 32'd0);
    push(4, 2, 3);
    issue_cycle(4, 1, 2, 0, 1, 3, 0);
    tick();
    check("t6_post_rst_start", 32'(mul_start), 32'd1);
    do_done();

    tick();
    tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
